// File: rtl/gps_acq_search_if.sv
// Result channel of the GPS acquisition engine: one best-peak record per satellite,
// offered with a valid/ready handshake.
interface gps_acq_search_if #(
    parameter int SAMPLE_BITS = 12,
    parameter int FRAC_W      = 2
);
    logic                   result_valid;
    logic                   result_ready;
    logic [5:0]             res_sat;
    logic [9:0]             res_code_phase;
    logic [FRAC_W-1:0]      res_code_frac;
    logic [15:0]            res_doppler;
    logic [SAMPLE_BITS+1:0] res_power;
    logic                   res_detected;

    modport master (output result_valid, res_sat, res_code_phase, res_code_frac,
                           res_doppler, res_power, res_detected,
                    input  result_ready);
    modport slave  (input  result_valid, res_sat, res_code_phase, res_code_frac,
                           res_doppler, res_power, res_detected,
                    output result_ready);
endinterface

// File: rtl/gps_acq_search.sv
// Serial acquisition search for 1-bit I/Q GPS L1 C/A samples: capture a block, then
// correlate every (Doppler, code phase, sub-chip) hypothesis per PRN and report the peak.
module gps_acq_search #(
    parameter int SAMPLE_BITS    = 12,
    parameter int CODE_PHASES    = 1023,
    parameter int CODE_NCO_BITS  = 9,
    parameter int CODE_NCO_OMEGA = 145,
    parameter int FRAC_STEPS     = 4,
    parameter int DOPPLER_NUM    = 8,
    parameter int SAT_FIRST      = 1,
    parameter int SAT_LAST       = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ack_start,
    input  logic                   adc_clk,
    input  logic                   i_sample,
    input  logic                   q_sample,
    input  logic [15:0]            doppler_init,
    input  logic [15:0]            doppler_step,
    input  logic [SAMPLE_BITS+1:0] threshold,
    output logic                   busy,
    output logic                   search_complete,
    gps_acq_search_if.master       res_if
);
    localparam int N  = 1 << SAMPLE_BITS;
    localparam int PW = SAMPLE_BITS + 2;
    localparam int AW = SAMPLE_BITS + 1;
    localparam int FW = (FRAC_STEPS > 1) ? $clog2(FRAC_STEPS) : 1;
    localparam int DW = (DOPPLER_NUM > 1) ? $clog2(DOPPLER_NUM) : 1;
    localparam logic [FW-1:0]            FRAC_LAST = FW'(FRAC_STEPS - 1);
    localparam logic [9:0]               CPH_LAST  = 10'(CODE_PHASES - 1);
    localparam logic [DW-1:0]            BIN_LAST  = DW'(DOPPLER_NUM - 1);
    localparam logic [5:0]               SAT_FIRST_V = 6'(SAT_FIRST);
    localparam logic [5:0]               SAT_LAST_V  = 6'(SAT_LAST);
    localparam logic [CODE_NCO_BITS-1:0] FRAC_INC  = CODE_NCO_BITS'((1 << CODE_NCO_BITS) / FRAC_STEPS);
    localparam logic [CODE_NCO_BITS:0]   NCO_INC   = (CODE_NCO_BITS+1)'(CODE_NCO_OMEGA);
    localparam logic signed [SAMPLE_BITS+2:0] N_S  = (SAMPLE_BITS+3)'(N);
    localparam logic [3:0] LO_I = 4'b1100;
    localparam logic [3:0] LO_Q = 4'b0110;

    typedef enum logic [2:0] {S_IDLE, S_CAPTURE, S_POINT_INIT, S_CORR, S_EVAL, S_REPORT, S_DONE} state_t;

    state_t                   state_q;
    logic [1:0]               sync_q;
    logic [N-1:0]             ibuf_q, qbuf_q;
    logic [SAMPLE_BITS-1:0]   idx_q;
    logic [15:0]              dinit_q, dstep_q, omega_q, phase_q;
    logic [PW-1:0]            thr_q;
    logic [5:0]               sat_q;
    logic [DW-1:0]            bin_q;
    logic [9:0]               cph_q;
    logic [FW-1:0]            frac_q;
    logic [10:1]              base_g1_q, base_g2_q, g1_q, g2_q;
    logic [CODE_NCO_BITS-1:0] nco_q;
    logic [AW-1:0]            acc_i_q, acc_q_q;
    logic [PW-1:0]            best_pow_q;
    logic [9:0]               best_cph_q;
    logic [FW-1:0]            best_frac_q;
    logic [15:0]              best_om_q;
    logic                     busy_q, done_q, valid_q, res_det_q;
    logic [5:0]               res_sat_q;
    logic [9:0]               res_cph_q;
    logic [FW-1:0]            res_frac_q;
    logic [15:0]              res_om_q;
    logic [PW-1:0]            res_pow_q;

    function automatic logic [10:1] g1_step(input logic [10:1] g);
        return {g[9:1], g[3] ^ g[10]};
    endfunction

    function automatic logic [10:1] g2_step(input logic [10:1] g);
        return {g[9:1], g[2] ^ g[3] ^ g[6] ^ g[8] ^ g[9] ^ g[10]};
    endfunction

    // G2 phase-selector tap pair per PRN, packed {tap1, tap2}.
    function automatic logic [7:0] g2_taps(input logic [5:0] prn);
        case (prn)
            6'd1:  return 8'h26;  6'd2:  return 8'h37;  6'd3:  return 8'h48;  6'd4:  return 8'h59;
            6'd5:  return 8'h19;  6'd6:  return 8'h2a;  6'd7:  return 8'h18;  6'd8:  return 8'h29;
            6'd9:  return 8'h3a;  6'd10: return 8'h23;  6'd11: return 8'h34;  6'd12: return 8'h56;
            6'd13: return 8'h67;  6'd14: return 8'h78;  6'd15: return 8'h89;  6'd16: return 8'h9a;
            6'd17: return 8'h14;  6'd18: return 8'h25;  6'd19: return 8'h36;  6'd20: return 8'h47;
            6'd21: return 8'h58;  6'd22: return 8'h69;  6'd23: return 8'h13;  6'd24: return 8'h46;
            6'd25: return 8'h57;  6'd26: return 8'h68;  6'd27: return 8'h79;  6'd28: return 8'h8a;
            6'd29: return 8'h16;  6'd30: return 8'h27;  6'd31: return 8'h38;  default: return 8'h49;
        endcase
    endfunction

    logic [3:0]                  tap1, tap2;
    logic                        chip, lo_i, lo_q, mi, mq, adc_rise, upd;
    logic [CODE_NCO_BITS:0]      nco_sum;
    logic [CODE_NCO_BITS-1:0]    nco_init;
    logic signed [SAMPLE_BITS+2:0] dev_i, dev_q, neg_i, neg_q;
    logic [PW-1:0]               abs_i, abs_q, power, nb_pow;
    logic [9:0]                  nb_cph;
    logic [FW-1:0]               nb_frac;
    logic [15:0]                 nb_om;

    always_comb begin
        {tap1, tap2} = g2_taps(sat_q);
        chip     = g1_q[10] ^ g2_q[tap1] ^ g2_q[tap2];
        lo_i     = LO_I[phase_q[15:14]];
        lo_q     = LO_Q[phase_q[15:14]];
        mi       = ~(ibuf_q[idx_q] ^ lo_i ^ chip);
        mq       = ~(qbuf_q[idx_q] ^ lo_q ^ chip);
        adc_rise = ~sync_q[1] & sync_q[0];
        nco_sum  = {1'b0, nco_q} + NCO_INC;
        nco_init = CODE_NCO_BITS'(frac_q) * FRAC_INC;
        // |2*acc - N| per arm; each term is at most N, so the sum fits in SAMPLE_BITS+2.
        dev_i    = $signed({1'b0, acc_i_q, 1'b0}) - N_S;
        dev_q    = $signed({1'b0, acc_q_q, 1'b0}) - N_S;
        neg_i    = -dev_i;
        neg_q    = -dev_q;
        abs_i    = dev_i[SAMPLE_BITS+2] ? neg_i[PW-1:0] : dev_i[PW-1:0];
        abs_q    = dev_q[SAMPLE_BITS+2] ? neg_q[PW-1:0] : dev_q[PW-1:0];
        power    = abs_i + abs_q;
        upd      = power > best_pow_q;
        nb_pow   = upd ? power   : best_pow_q;
        nb_cph   = upd ? cph_q   : best_cph_q;
        nb_frac  = upd ? frac_q  : best_frac_q;
        nb_om    = upd ? omega_q : best_om_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;      sync_q <= '0;       ibuf_q <= '0;      qbuf_q <= '0;
            idx_q <= '0;            dinit_q <= '0;      dstep_q <= '0;     omega_q <= '0;
            phase_q <= '0;          thr_q <= '0;        sat_q <= '0;       bin_q <= '0;
            cph_q <= '0;            frac_q <= '0;       base_g1_q <= '0;   base_g2_q <= '0;
            g1_q <= '0;             g2_q <= '0;         nco_q <= '0;       acc_i_q <= '0;
            acc_q_q <= '0;          best_pow_q <= '0;   best_cph_q <= '0;  best_frac_q <= '0;
            best_om_q <= '0;        busy_q <= 1'b0;     done_q <= 1'b0;    valid_q <= 1'b0;
            res_det_q <= 1'b0;      res_sat_q <= '0;    res_cph_q <= '0;   res_frac_q <= '0;
            res_om_q <= '0;         res_pow_q <= '0;
        end else begin
            sync_q <= {sync_q[0], adc_clk};
            case (state_q)
                S_IDLE: if (ack_start) begin
                    dinit_q <= doppler_init;  dstep_q <= doppler_step;  thr_q <= threshold;
                    omega_q <= doppler_init;  sat_q <= SAT_FIRST_V;
                    busy_q <= 1'b1;           done_q <= 1'b0;           idx_q <= '0;
                    bin_q <= '0;  cph_q <= '0;  frac_q <= '0;  base_g1_q <= '1;  base_g2_q <= '1;
                    best_pow_q <= '0;  best_cph_q <= '0;  best_frac_q <= '0;  best_om_q <= '0;
                    state_q <= S_CAPTURE;
                end
                S_CAPTURE: if (adc_rise) begin
                    ibuf_q[idx_q] <= i_sample;
                    qbuf_q[idx_q] <= q_sample;
                    idx_q <= idx_q + SAMPLE_BITS'(1);
                    if (idx_q == '1) state_q <= S_POINT_INIT;
                end
                S_POINT_INIT: begin
                    g1_q <= base_g1_q;  g2_q <= base_g2_q;  nco_q <= nco_init;
                    phase_q <= '0;  acc_i_q <= '0;  acc_q_q <= '0;  idx_q <= '0;
                    state_q <= S_CORR;
                end
                S_CORR: begin
                    acc_i_q <= acc_i_q + AW'(mi);
                    acc_q_q <= acc_q_q + AW'(mq);
                    phase_q <= phase_q + omega_q;
                    nco_q   <= nco_sum[CODE_NCO_BITS-1:0];
                    // A code-NCO carry advances the replica one chip, effective next sample.
                    if (nco_sum[CODE_NCO_BITS]) begin
                        g1_q <= g1_step(g1_q);
                        g2_q <= g2_step(g2_q);
                    end
                    idx_q <= idx_q + SAMPLE_BITS'(1);
                    if (idx_q == '1) state_q <= S_EVAL;
                end
                S_EVAL: begin
                    best_pow_q <= nb_pow;  best_cph_q <= nb_cph;
                    best_frac_q <= nb_frac;  best_om_q <= nb_om;
                    state_q <= S_POINT_INIT;
                    if (frac_q != FRAC_LAST) frac_q <= frac_q + FW'(1);
                    else begin
                        frac_q <= '0;
                        if (cph_q != CPH_LAST) begin
                            cph_q <= cph_q + 10'd1;
                            base_g1_q <= g1_step(base_g1_q);
                            base_g2_q <= g2_step(base_g2_q);
                        end else begin
                            cph_q <= '0;  base_g1_q <= '1;  base_g2_q <= '1;
                            if (bin_q != BIN_LAST) begin
                                bin_q <= bin_q + DW'(1);
                                omega_q <= omega_q + dstep_q;
                            end else begin
                                bin_q <= '0;  valid_q <= 1'b1;  res_sat_q <= sat_q;
                                res_cph_q <= nb_cph;  res_frac_q <= nb_frac;  res_om_q <= nb_om;
                                res_pow_q <= nb_pow;  res_det_q <= (nb_pow >= thr_q);
                                state_q <= S_REPORT;
                            end
                        end
                    end
                end
                S_REPORT: if (res_if.result_ready) begin
                    valid_q <= 1'b0;  omega_q <= dinit_q;  sat_q <= sat_q + 6'd1;
                    best_pow_q <= '0;  best_cph_q <= '0;  best_frac_q <= '0;  best_om_q <= '0;
                    state_q <= (sat_q == SAT_LAST_V) ? S_DONE : S_POINT_INIT;
                end
                S_DONE: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy                  = busy_q;
    assign search_complete       = done_q;
    assign res_if.result_valid   = valid_q;
    assign res_if.res_sat        = res_sat_q;
    assign res_if.res_code_phase = res_cph_q;
    assign res_if.res_code_frac  = res_frac_q;
    assign res_if.res_doppler    = res_om_q;
    assign res_if.res_power      = res_pow_q;
    assign res_if.res_detected   = res_det_q;
endmodule

// File: tb/tb_gps_acq_search.sv
// Bench for gps_acq_search on a shrunk search space; expected peaks come from a
// direct arithmetic correlation over PRN codes built with the G2-delay definition.
module tb_gps_acq_search;
    localparam int SB = 6, N = 1 << SB, CP = 5, CNB = 9, OM = 256, FS = 2, DN = 3;
    localparam int SF = 1, SL = 4, FW = 1, PW = SB + 2, BUDGET = 6000;
    localparam int DLY [0:31] = '{5, 6, 7, 8, 17, 18, 139, 140, 141, 251, 252, 254, 255, 256,
                                  257, 258, 469, 470, 471, 472, 473, 474, 509, 512, 513, 514,
                                  515, 516, 859, 860, 861, 862};

    logic clk = 1'b0, rst = 1'b0, ack_start = 1'b0, adc_clk = 1'b0;
    logic i_sample = 1'b0, q_sample = 1'b0;
    logic [15:0] doppler_init = '0, doppler_step = '0;
    logic [PW-1:0] threshold = '0;
    logic busy, search_complete;

    gps_acq_search_if #(.SAMPLE_BITS(SB), .FRAC_W(FW)) rif ();

    gps_acq_search #(.SAMPLE_BITS(SB), .CODE_PHASES(CP), .CODE_NCO_BITS(CNB), .CODE_NCO_OMEGA(OM),
                     .FRAC_STEPS(FS), .DOPPLER_NUM(DN), .SAT_FIRST(SF), .SAT_LAST(SL)) dut (
        .clk(clk), .rst(rst), .ack_start(ack_start), .adc_clk(adc_clk),
        .i_sample(i_sample), .q_sample(q_sample), .doppler_init(doppler_init),
        .doppler_step(doppler_step), .threshold(threshold), .busy(busy),
        .search_complete(search_complete), .res_if(rif));

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    bit code [1:32][0:1022];
    bit si [0:N-1], sq [0:N-1];
    logic [15:0] dinit_l, dstep_l;
    logic [PW-1:0] thr_l;
    int e_ph [0:63], e_fr [0:63], e_pw [0:63], o_ph [0:63], o_fr [0:63], o_pw [0:63];
    logic [15:0] e_om [0:63], o_om [0:63];
    bit e_det [0:63], o_det [0:63];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic build_codes();
        bit [10:1] a, b;
        bit g1s [0:1022], g2s [0:1022];
        a = '1; b = '1;
        for (int i = 0; i < 1023; i++) begin
            g1s[i] = a[10]; g2s[i] = b[10];
            a = {a[9:1], a[3] ^ a[10]};
            b = {b[9:1], b[2] ^ b[3] ^ b[6] ^ b[8] ^ b[9] ^ b[10]};
        end
        for (int p = 1; p <= 32; p++)
            for (int i = 0; i < 1023; i++)
                code[p][i] = g1s[i] ^ g2s[(i + 1023 - DLY[p-1]) % 1023];
    endtask

    // Exhaustive correlation in the engine's search order; strict '>' keeps the first peak.
    task automatic model_run();
        int bp, bph, bfr, ai, aq, pw, ci, di, dq;
        logic [15:0] bom, om, ph;
        bit c;
        for (int s = SF; s <= SL; s++) begin
            bp = 0; bph = 0; bfr = 0; bom = '0;
            for (int b = 0; b < DN; b++) begin
                om = dinit_l + 16'(b) * dstep_l;
                for (int p = 0; p < CP; p++)
                    for (int f = 0; f < FS; f++) begin
                        ai = 0; aq = 0; ph = '0;
                        for (int k = 0; k < N; k++) begin
                            ci = (p + (f * ((1 << CNB) / FS) + k * OM) / (1 << CNB)) % 1023;
                            c = code[s][ci];
                            if ((si[k] ^ ph[15] ^ c) == 1'b0) ai++;
                            if ((sq[k] ^ ph[15] ^ ph[14] ^ c) == 1'b0) aq++;
                            ph = ph + om;
                        end
                        di = 2 * ai - N; dq = 2 * aq - N;
                        pw = (di < 0 ? -di : di) + (dq < 0 ? -dq : dq);
                        if (pw > bp) begin bp = pw; bph = p; bfr = f; bom = om; end
                    end
            end
            e_ph[s] = bph; e_fr[s] = bfr; e_om[s] = bom; e_pw[s] = bp; e_det[s] = (bp >= int'(thr_l));
        end
    endtask

    task automatic gen_random();
        for (int k = 0; k < N; k++) begin si[k] = 1'($urandom); sq[k] = 1'($urandom); end
    endtask

    task automatic gen_signal(input int prn, input int cph, input logic [15:0] om);
        logic [15:0] ph;
        bit c;
        ph = '0;
        for (int k = 0; k < N; k++) begin
            c = code[prn][(cph + (k * OM) / (1 << CNB)) % 1023];
            si[k] = c ^ ph[15];
            sq[k] = c ^ ph[15] ^ ph[14];
            ph = ph + om;
        end
    endtask

    task automatic start_run(input logic [15:0] di, input logic [15:0] ds, input logic [PW-1:0] th);
        dinit_l = di; dstep_l = ds; thr_l = th;
        model_run();
        doppler_init = di; doppler_step = ds; threshold = th;
        ack_start = 1'b1;
        @(negedge clk);
        ack_start = 1'b0;
        check("busy_on_start", 64'(busy), 64'd1);
        check("complete_cleared", 64'(search_complete), 64'd0);
        for (int k = 0; k < N; k++) begin
            i_sample = si[k]; q_sample = sq[k];
            #50 adc_clk = 1'b1;
            #50 adc_clk = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic get_results(input int stall);
        int t;
        logic [33+FW+PW-1:0] expv, got;
        for (int s = SF; s <= SL; s++) begin
            t = 0;
            while (rif.result_valid !== 1'b1 && t < BUDGET) begin @(negedge clk); t++; end
            check("result_wait", 64'(t < BUDGET), 64'd1);
            if (t >= BUDGET) return;
            expv = {6'(s), 10'(e_ph[s]), FW'(e_fr[s]), e_om[s], PW'(e_pw[s]), e_det[s]};
            for (int c = 0; c < stall; c++) begin
                got = {rif.res_sat, rif.res_code_phase, rif.res_code_frac, rif.res_doppler,
                       rif.res_power, rif.res_detected};
                check("hold_valid", 64'(rif.result_valid), 64'd1);
                check("hold_fields", 64'(got), 64'(expv));
                @(negedge clk);
            end
            check("res_sat", 64'(rif.res_sat), 64'(s));
            check("res_code_phase", 64'(rif.res_code_phase), 64'(e_ph[s]));
            check("res_code_frac", 64'(rif.res_code_frac), 64'(e_fr[s]));
            check("res_doppler", 64'(rif.res_doppler), 64'(e_om[s]));
            check("res_power", 64'(rif.res_power), 64'(e_pw[s]));
            check("res_detected", 64'(rif.res_detected), 64'(e_det[s]));
            o_ph[s] = int'(rif.res_code_phase); o_fr[s] = int'(rif.res_code_frac);
            o_om[s] = rif.res_doppler; o_pw[s] = int'(rif.res_power); o_det[s] = rif.res_detected;
            rif.result_ready = 1'b1;
            @(negedge clk);
            rif.result_ready = 1'b0;
            check("valid_drop", 64'(rif.result_valid), 64'd0);
        end
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (search_complete !== 1'b1 && t < BUDGET) begin @(negedge clk); t++; end
        check("done_wait", 64'(t < BUDGET), 64'd1);
        check("busy_done", 64'(busy), 64'd0);
        check("valid_done", 64'(rif.result_valid), 64'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rif.result_ready = 1'b0;
        build_codes();
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_complete", 64'(search_complete), 64'd0);
        check("rst_valid", 64'(rif.result_valid), 64'd0);
        check("rst_fields", 64'({rif.res_sat, rif.res_code_phase, rif.res_doppler, rif.res_power}), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // Random samples, stalled consumer, stray start request mid-search.
        gen_random();
        start_run(16'($urandom), 16'($urandom), PW'($urandom_range(20, 50)));
        repeat (40) @(negedge clk);
        doppler_init = ~doppler_init;
        ack_start = 1'b1;
        @(negedge clk);
        ack_start = 1'b0;
        check("ack_ignored_busy", 64'(busy), 64'd1);
        get_results(50);
        wait_done();

        // PRN3 at code phase 3 with carrier +2048 in a -2048/0/+2048 bin set.
        gen_signal(3, 3, 16'd2048);
        start_run(16'hF800, 16'd2048, PW'(100));
        get_results(0);
        wait_done();
        check("prn3_phase", 64'(o_ph[3]), 64'd3);
        check("prn3_frac", 64'(o_fr[3]), 64'd0);
        check("prn3_doppler", 64'(o_om[3]), 64'h0800);
        check("prn3_power", 64'(o_pw[3]), 64'd128);
        check("prn3_detected", 64'(o_det[3]), 64'd1);

        // PRN2 at code phase 1 with carrier -2048, threshold above any reachable power.
        gen_signal(2, 1, 16'hF800);
        start_run(16'hF800, 16'd2048, PW'(200));
        get_results(2);
        wait_done();
        check("prn2_phase", 64'(o_ph[2]), 64'd1);
        check("prn2_doppler", 64'(o_om[2]), 64'hF800);
        check("prn2_power", 64'(o_pw[2]), 64'd128);
        check("prn2_detected", 64'(o_det[2]), 64'd0);

        // Abort mid-correlation, then a clean restart.
        gen_random();
        start_run(16'($urandom), 16'($urandom), PW'($urandom_range(20, 50)));
        repeat (100) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_valid", 64'(rif.result_valid), 64'd0);
        check("abort_complete", 64'(search_complete), 64'd0);
        check("abort_fields", 64'({rif.res_sat, rif.res_code_phase, rif.res_code_frac,
                                   rif.res_doppler, rif.res_power, rif.res_detected}), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        gen_random();
        start_run(16'($urandom), 16'($urandom), PW'($urandom_range(20, 50)));
        get_results(3);
        wait_done();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/gps_acq_search.md
Name: gps_acq_search

Overview:
- Parametrised acquisition engine for 1-bit I/Q GPS L1 C/A samples.
- Captures 2^SAMPLE_BITS samples on adc_clk rising edges, then searches satellites SAT_FIRST..SAT_LAST over all Doppler bins, code phases and sub-chip fractions.
- Uses complex (I and Q) carrier wipe-off.
- Reports one best-peak result per satellite over a valid/ready handshake.

Parameters:
SAMPLE_BITS, 12, log2 of capture length N
CODE_PHASES, 1023, code-phase hypotheses per bin
CODE_NCO_BITS, 9, code NCO accumulator width
CODE_NCO_OMEGA, 145, code NCO increment per sample
FRAC_STEPS, 4, sub-chip hypotheses per code phase (power of 2)
DOPPLER_NUM, 8, Doppler bins per satellite
SAT_FIRST, 1, first PRN searched (1..32)
SAT_LAST, 32, last PRN searched (>= SAT_FIRST)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
ack_start  in  1  start request; sampled only in IDLE
adc_clk  in  1  ADC sample clock, asynchronous to clk
i_sample  in  1  in-phase sign bit
q_sample  in  1  quadrature sign bit
doppler_init  in  16  signed start carrier omega, latched at start
doppler_step  in  16  signed omega step per bin, latched at start
threshold  in  SAMPLE_BITS+2  detection threshold, latched at start
busy  out  1  high from start accepted until DONE
result_valid  out  1  per-satellite result available
result_ready  in  1  consumer accepts result
res_sat  out  6  PRN of result
res_code_phase  out  10  best code phase
res_code_frac  out  log2(FRAC_STEPS) or 1  best fraction index
res_doppler  out  16  signed best omega
res_power  out  SAMPLE_BITS+2  best power
res_detected  out  1  res_power >= threshold
search_complete  out  1  level; set at DONE, cleared by next accepted start

Behaviour:
- Reset: state IDLE. All outputs 0. Sample buffers, counters and accumulators cleared. Reset mid-operation aborts at once.
- adc_clk: 2-flop synchroniser; rising edge = sync[1]==0 && sync[0]==1.
- IDLE -> CAPTURE on ack_start. Latch doppler_init/doppler_step/threshold, sat=SAT_FIRST, busy=1, search_complete=0.
- CAPTURE: each edge stores sample k at index k (k=0..N-1). After index N-1 -> POINT_INIT.
- POINT_INIT (1 cycle):
  - g1,g2 <= base LFSR state for current code phase.
  - code_nco <= frac*(2^CODE_NCO_BITS/FRAC_STEPS).
  - carrier phase <= 0; acc_i=acc_q=0; sample idx=0.
  - -> CORR.
- CORR (N cycles), per sample k:
  - chip c = g1[10]^g2[t1]^g2[t2], using IS-GPS-200 G2 phase-selector taps (PRN1=2,6 ... PRN32=4,9).
  - lo_i/lo_q = bit phase[15:14] of 4'b1100 / 4'b0110.
  - acc_i += !(i[k]^lo_i^c); acc_q += !(q[k]^lo_q^c).
  - Carrier phase += omega, mod 2^16. lo is taken from phase before the add.
  - code_nco += CODE_NCO_OMEGA. On carry-out, shift g1 (feedback 3^10) and g2 (feedback 2^3^6^8^9^10) one chip; the new chip is used from sample k+1.
- EVAL (1 cycle):
  - power = |2*acc_i-N| + |2*acc_q-N|, width SAMPLE_BITS+2, no overflow.
  - If power > best (strict; first maximum wins), update best power/phase/frac/omega.
- ADVANCE: loop order, innermost first, is frac, then code phase, then Doppler bin.
  - Code-phase increment shifts base LFSR one chip.
  - Doppler increment: omega += step (wrap mod 2^16); code phase and base LFSR reset to phase 0 / all-ones.
  - Next point -> POINT_INIT. All points of satellite done -> REPORT.
- REPORT:
  - result_valid=1, fields stable while valid.
  - On valid&&ready (same cycle): valid=0, best cleared, omega=doppler_init, sat++.
  - If sat was SAT_LAST -> DONE, else -> POINT_INIT.
  - ready low holds indefinitely.
- DONE (1 cycle): busy=0, search_complete=1 -> IDLE.
- ack_start while busy is ignored.
- Latency per point: N+2 cycles. Capture buffer is not re-sampled during the search.

Test Plan:
- Reset mid-CORR -> next cycle busy=0, result_valid=0, search_complete=0, all res_* = 0; new ack_start restarts capture cleanly.
- Code-generator check: PRN1, phase 0, frac 0, CODE_NCO_OMEGA=256, CODE_NCO_BITS=9 -> first 10 chips used are 1100100000 (two samples each).
- SAMPLE_BITS=11, FRAC_STEPS=2, DOPPLER_NUM=1, SAT 3..3, OMEGA=256, doppler_init=0, i = periodic PRN3 delayed 5 chips (2 samples/chip), q=0:
  - one result: res_sat=3, res_code_phase=5, res_code_frac=0, res_doppler=0, res_power>=2048.
  - threshold=1500 -> res_detected=1; threshold=4000 -> res_detected=0.
- SAT 1..4, random samples, result_ready held low 50 cycles per result -> result_valid and fields stable until ready; res_sat sequence 1,2,3,4; then search_complete=1, busy=0.
- DOPPLER_NUM=3, doppler_init=-13, step=13, i/q built with carrier omega=+13 -> res_doppler=13; omega=-13 input -> res_doppler=-13 (0xFFF3).
- ack_start pulsed during CORR -> ignored, search order and results unchanged; ack_start after DONE clears search_complete.
